// File: rtl/alu_mdu_pkg.sv
// alu_mdu_pkg -- shared control constants for the ALU / multiply-divide unit.
//
// Contents:
//   alu_op_e     ALUOp encodings (combinational ALU result select)
//   cmp_op_e     CMPOp encodings (branch compare select)
//   mdu_op_e     MDUOp encodings (multiply / divide / HI-LO moves)
//   mdu_state_e  multiply/divide sequencer states
//   MULT_CYCLES_DEF, DIV_CYCLES_DEF  default busy-cycle counts
package alu_mdu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_LUI  = 4'd5,
        ALU_SLT  = 4'd6,
        ALU_SLTU = 4'd7
    } alu_op_e;

    typedef enum logic [3:0] {
        CMP_BEQ  = 4'd0,
        CMP_BNE  = 4'd1,
        CMP_BLTZ = 4'd2,
        CMP_BGEZ = 4'd3
    } cmp_op_e;

    typedef enum logic [3:0] {
        MDU_NOP   = 4'd0,
        MDU_MULT  = 4'd1,
        MDU_MULTU = 4'd2,
        MDU_DIV   = 4'd3,
        MDU_DIVU  = 4'd4,
        MDU_MTHI  = 4'd5,
        MDU_MTLO  = 4'd6
    } mdu_op_e;

    typedef enum logic {
        MDU_IDLE = 1'b0,
        MDU_BUSY = 1'b1
    } mdu_state_e;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

endpackage

// File: rtl/alu_mdu_mdu.sv
// mdu_core -- multi-cycle multiply/divide unit with HI/LO registers.
//
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   a_i, b_i       operands (latched when an operation is accepted)
//   op_i, start_i  MDUOp and one-cycle start request
//   hi_o, lo_o     HI / LO registers
//   state_o        sequencer state (IDLE / BUSY); Busy is derived from it
//
// Handshake: start_i is accepted only in IDLE. MULT/MULTU/DIV/DIVU move
// to BUSY for a fixed number of cycles; HI/LO update on the edge that ends
// the last busy cycle, which is also the edge that returns to IDLE.
// MTHI/MTLO write at the accepting edge with no busy cycles. Starts seen
// while BUSY are dropped; the issuer is expected to stall on Busy.
//
// Macro ALU_MDU_SIGNED_EN: when defined, MULT/DIV use signed arithmetic;
// otherwise they are identical to MULTU/DIVU.
module mdu_core
    import alu_mdu_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [3:0]       op_i,
    input  logic             start_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output mdu_state_e       state_o
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);

    mdu_state_e       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;

    logic signed_op;
`ifdef ALU_MDU_SIGNED_EN
    assign signed_op = (op_q == MDU_MULT) || (op_q == MDU_DIV);
`else
    assign signed_op = 1'b0;
`endif

    logic is_mul_q;
    assign is_mul_q = (op_q == MDU_MULT) || (op_q == MDU_MULTU);

    // Multiply: extend both operands to 2*WIDTH (sign or zero) so a single
    // truncated product gives the correct signed or unsigned result.
    logic [2*WIDTH-1:0] mul_a, mul_b, prod;
    assign mul_a = signed_op ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
    assign mul_b = signed_op ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
    assign prod  = mul_a * mul_b;

    // Divide on magnitudes, then restore signs: quotient truncates toward
    // zero, remainder follows the dividend. most-negative / -1 falls out
    // naturally as quotient = most-negative, remainder = 0.
    logic             a_neg, b_neg, div_by_zero;
    logic [WIDTH-1:0] a_mag, b_mag, quo_mag, rem_mag, quo, rem;
    assign a_neg       = signed_op & a_q[WIDTH-1];
    assign b_neg       = signed_op & b_q[WIDTH-1];
    assign a_mag       = a_neg ? (WIDTH'(0) - a_q) : a_q;
    assign b_mag       = b_neg ? (WIDTH'(0) - b_q) : b_q;
    assign div_by_zero = (b_q == '0);
    assign quo_mag     = div_by_zero ? '0 : (a_mag / b_mag);
    assign rem_mag     = div_by_zero ? '0 : (a_mag % b_mag);
    assign quo         = (a_neg ^ b_neg) ? (WIDTH'(0) - quo_mag) : quo_mag;
    assign rem         = a_neg ? (WIDTH'(0) - rem_mag) : rem_mag;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            MDU_IDLE: begin
                if (start_i) begin
                    case (op_i)
                        MDU_MULT, MDU_MULTU: begin
                            a_d     = a_i;
                            b_d     = b_i;
                            op_d    = op_i;
                            cnt_d   = MULT_LOAD;
                            state_d = MDU_BUSY;
                        end
                        MDU_DIV, MDU_DIVU: begin
                            a_d     = a_i;
                            b_d     = b_i;
                            op_d    = op_i;
                            cnt_d   = DIV_LOAD;
                            state_d = MDU_BUSY;
                        end
                        MDU_MTHI: hi_d = a_i;
                        MDU_MTLO: lo_d = a_i;
                        default: ;
                    endcase
                end
            end
            MDU_BUSY: begin
                if (cnt_q == CW'(1)) begin
                    state_d = MDU_IDLE;
                    cnt_d   = '0;
                    if (is_mul_q) begin
                        hi_d = prod[2*WIDTH-1:WIDTH];
                        lo_d = prod[WIDTH-1:0];
                    end else if (!div_by_zero) begin
                        hi_d = rem;
                        lo_d = quo;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = MDU_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= MDU_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign hi_o    = hi_q;
    assign lo_o    = lo_q;
    assign state_o = state_q;

endmodule

// File: rtl/alu_mdu.sv
// alu_mdu -- combinational ALU and branch comparator plus a multi-cycle
// multiply/divide unit (mdu_core) holding HI/LO.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   A, B                  operands
//   ALUOp, CMPOp, MDUOp   operation selects (encodings in alu_mdu_pkg)
//   Start                 one-cycle request to execute MDUOp
//   ALURes, Branch        combinational ALU result / compare result
//   HI, LO                multiply/divide result registers
//   Busy                  multiply/divide in flight (MDU sequencer in BUSY)
//
// Macro ALU_MDU_SIGNED_EN (consumed by mdu_core): enables signed MULT/DIV.
module alu_mdu
    import alu_mdu_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       ALUOp,
    input  logic [3:0]       CMPOp,
    input  logic [3:0]       MDUOp,
    input  logic             Start,
    output logic [WIDTH-1:0] ALURes,
    output logic             Branch,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic             Busy
);

    mdu_state_e mdu_state;

    always_comb begin
        ALURes = '0;
        case (ALUOp)
            ALU_ADD:  ALURes = A + B;
            ALU_SUB:  ALURes = A - B;
            ALU_AND:  ALURes = A & B;
            ALU_OR:   ALURes = A | B;
            ALU_XOR:  ALURes = A ^ B;
            ALU_LUI:  ALURes = B << (WIDTH / 2);
            ALU_SLT:  ALURes = WIDTH'($signed(A) < $signed(B));
            ALU_SLTU: ALURes = WIDTH'(A < B);
            default:  ALURes = '0;
        endcase
    end

    always_comb begin
        Branch = 1'b0;
        case (CMPOp)
            CMP_BEQ:  Branch = (A == B);
            CMP_BNE:  Branch = (A != B);
            CMP_BLTZ: Branch = A[WIDTH-1];
            CMP_BGEZ: Branch = ~A[WIDTH-1];
            default:  Branch = 1'b0;
        endcase
    end

    mdu_core #(
        .WIDTH       (WIDTH),
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES)
    ) u_mdu (
        .clk     (clk),
        .reset   (reset),
        .a_i     (A),
        .b_i     (B),
        .op_i    (MDUOp),
        .start_i (Start),
        .hi_o    (HI),
        .lo_o    (LO),
        .state_o (mdu_state)
    );

    assign Busy = (mdu_state == MDU_BUSY);

endmodule

// File: tb/tb_alu_mdu.sv
// Testbench for alu_mdu: directed and random stimulus, reference model,
// expected-result queue popped by a monitor when Busy falls.
module tb_alu_mdu;
    import alu_mdu_pkg::*;

    localparam int W  = 32;
    localparam int MC = 5;
    localparam int DC = 10;

    // ---------------- clock / reset / DUT ----------------
    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] A, B;
    logic [3:0]   ALUOp, CMPOp, MDUOp;
    logic         Start;
    logic [W-1:0] ALURes, HI, LO;
    logic         Branch, Busy;

    always #5 clk = ~clk;

    alu_mdu #(.WIDTH(W), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .A(A), .B(B),
        .ALUOp(ALUOp), .CMPOp(CMPOp), .MDUOp(MDUOp), .Start(Start),
        .ALURes(ALURes), .Branch(Branch), .HI(HI), .LO(LO), .Busy(Busy)
    );

    // ---------------- scoreboard state ----------------
    int n_vec = 0;
    int n_err = 0;
    logic [2*W+7:0] exp_q[$];     // {busy_cycles[7:0], hi, lo}
    logic [W-1:0]   m_hi = '0, m_lo = '0;     // architectural HI/LO model
    logic [W-1:0]   pre_hi = '0, pre_lo = '0; // values that must hold while busy

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic report;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    endtask

    // ---------------- reference model ----------------
    function automatic logic [W-1:0] alu_ref(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa, sb, ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'(a);
        ub = longint'(b);
        case (op)
            ALU_ADD:  return W'(ua + ub);
            ALU_SUB:  return W'(ua - ub);
            ALU_AND:  return a & b;
            ALU_OR:   return a | b;
            ALU_XOR:  return a ^ b;
            ALU_LUI:  return W'(ub * (64'd1 << (W / 2)));
            ALU_SLT:  return (sa < sb) ? W'(1) : W'(0);
            ALU_SLTU: return (ua < ub) ? W'(1) : W'(0);
            default:  return '0;
        endcase
    endfunction

    function automatic logic cmp_ref(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa;
        sa = longint'($signed(a));
        case (op)
            CMP_BEQ:  return a == b;
            CMP_BNE:  return a != b;
            CMP_BLTZ: return sa < 0;
            CMP_BGEZ: return sa >= 0;
            default:  return 1'b0;
        endcase
    endfunction

    // Next HI/LO and busy-cycle count for an accepted op (cyc=0: no busy phase).
    task automatic mdu_ref(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                           output int cyc, output logic [W-1:0] hi, output logic [W-1:0] lo);
        bit     sgn;
        longint sa, sb, q, r;
        logic [63:0] p;
        hi  = m_hi;
        lo  = m_lo;
        cyc = 0;
`ifdef ALU_MDU_SIGNED_EN
        sgn = (op == MDU_MULT) || (op == MDU_DIV);
`else
        sgn = 1'b0;
`endif
        sa = sgn ? longint'($signed(a)) : longint'(a);
        sb = sgn ? longint'($signed(b)) : longint'(b);
        case (op)
            MDU_MULT, MDU_MULTU: begin
                cyc = MC;
                p   = sa * sb;
                hi  = p[2*W-1:W];
                lo  = p[W-1:0];
            end
            MDU_DIV, MDU_DIVU: begin
                cyc = DC;
                if (b != '0) begin
                    q  = sa / sb;
                    r  = sa % sb;
                    lo = q[W-1:0];
                    hi = r[W-1:0];
                end
            end
            MDU_MTHI: hi = a;
            MDU_MTLO: lo = a;
            default: ;
        endcase
    endtask

    // ---------------- driver tasks ----------------
    // All MDU driver tasks start and end at posedge+#1.
    task automatic wait_idle;
        int k;
        k = 0;
        while (Busy && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        if (Busy) begin
            n_vec++;
            n_err++;
            $display("FAIL wait_idle: Busy still %b after %0d cycles, expected 0", Busy, k);
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input bit wait_first);
        int           cyc;
        logic [W-1:0] ehi, elo;
        bit           acc;
        cyc = 0;
        if (wait_first) wait_idle();
        acc   = !Busy;
        A     = a;
        B     = b;
        MDUOp = op;
        Start = 1'b1;
        if (acc) begin
            mdu_ref(op, a, b, cyc, ehi, elo);
            if (cyc > 0) begin
                pre_hi = m_hi;
                pre_lo = m_lo;
                exp_q.push_back({8'(cyc), ehi, elo});
            end
            m_hi = ehi;
            m_lo = elo;
        end
        @(posedge clk); #1;
        Start = 1'b0;
        MDUOp = MDU_NOP;
        A     = $urandom;   // operands must be isolated once latched
        B     = $urandom;
        if (acc && cyc == 0) begin
            check("mdu_hi_immediate", HI, m_hi);
            check("mdu_lo_immediate", LO, m_lo);
            check("mdu_no_busy", Busy, 0);
        end
    endtask

    task automatic alu_chk(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        ALUOp = op; A = a; B = b;
        #1;
        check("alu_res", ALURes, alu_ref(op, a, b));
    endtask

    task automatic cmp_chk(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        CMPOp = op; A = a; B = b;
        #1;
        check("branch", Branch, cmp_ref(op, a, b));
    endtask

    // ---------------- monitor ----------------
    int             mon_bc = 0;
    bit             mon_pb = 1'b0;
    logic [2*W+7:0] mon_e;

    initial begin
        forever begin
            @(negedge clk);
            if (Busy) begin
                mon_bc++;
                check("hi_hold_busy", HI, pre_hi);
                check("lo_hold_busy", LO, pre_lo);
            end else if (mon_pb) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_done: Busy fell with HI=%h LO=%h, no result expected", HI, LO);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("busy_cycles", mon_bc, mon_e[2*W+7:2*W]);
                    check("hi_result", HI, mon_e[2*W-1:W]);
                    check("lo_result", LO, mon_e[W-1:0]);
                end
                mon_bc = 0;
            end
            mon_pb = Busy;
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        n_err++;
        $display("FAIL timeout: simulation did not complete");
        report();
        $finish;
    end

    // ---------------- stimulus ----------------
    logic [3:0] mdu_ops [8];
    logic [3:0] op;
    logic [W-1:0] ra, rb;

    initial begin
        mdu_ops = '{MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU, MDU_MTHI, MDU_MTLO, MDU_NOP, 4'd11};
        reset = 1'b1; Start = 1'b0; A = '0; B = '0;
        ALUOp = ALU_ADD; CMPOp = CMP_BEQ; MDUOp = MDU_NOP;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check("reset_hi", HI, 0);
        check("reset_lo", LO, 0);
        check("reset_busy", Busy, 0);

        // ALU / compare directed points
        ALUOp = ALU_SUB; A = 5; B = 7; #1;
        check("sub_5_7", ALURes, 32'hFFFF_FFFE);
        ALUOp = ALU_SLT; #1;
        check("slt_5_7", ALURes, 32'h1);
        ALUOp = ALU_SLTU; A = 32'hFFFF_FFFF; B = 1; #1;
        check("sltu_max_1", ALURes, 32'h0);
        ALUOp = ALU_LUI; B = 32'h0000_ABCD; #1;
        check("lui", ALURes, 32'hABCD_0000);
        CMPOp = CMP_BNE; A = 32'h1234; B = 32'h1234; #1;
        check("bne_equal", Branch, 0);
        CMPOp = CMP_BLTZ; A = 32'h8000_0000; #1;
        check("bltz_minneg", Branch, 1);

        // ALU / compare random, including undefined selects
        for (int i = 0; i < 40; i++) begin
            ra = $urandom; rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
            alu_chk(4'($urandom_range(0, 9)), ra, rb);
            cmp_chk(4'($urandom_range(0, 5)), ra, rb);
        end

        @(posedge clk); #1;

        // MULT / MULTU of 0xFFFFFFFF * 2
        issue(MDU_MULT, 32'hFFFF_FFFF, 32'd2, 1'b1);
        wait_idle();
`ifdef ALU_MDU_SIGNED_EN
        check("mult_hi", HI, 32'hFFFF_FFFF);
        check("mult_lo", LO, 32'hFFFF_FFFE);
`else
        check("mult_hi", HI, 32'h0000_0001);
        check("mult_lo", LO, 32'hFFFF_FFFE);
`endif
        issue(MDU_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b1);
        wait_idle();
        check("multu_hi", HI, 32'h0000_0001);
        check("multu_lo", LO, 32'hFFFF_FFFE);

        // DIV -7 / 2, then DIVU by zero leaves HI/LO alone
        issue(MDU_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1);
        wait_idle();
`ifdef ALU_MDU_SIGNED_EN
        check("div_lo", LO, 32'hFFFF_FFFD);
        check("div_hi", HI, 32'hFFFF_FFFF);
`else
        check("div_lo", LO, 32'h7FFF_FFFC);
        check("div_hi", HI, 32'h0000_0001);
`endif
        issue(MDU_DIVU, 32'd1234, 32'd0, 1'b1);
        wait_idle();
        check("div0_lo", LO, m_lo);
        check("div0_hi", HI, m_hi);

        // most-negative / -1
        issue(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        wait_idle();

        // starts during busy are dropped
        issue(MDU_DIVU, 32'd100, 32'd7, 1'b1);
        issue(MDU_MULT, 32'd3, 32'd3, 1'b0);
        issue(MDU_MTLO, 32'h55, 32'd0, 1'b0);
        wait_idle();
        check("busy_start_lo", LO, 32'd14);
        check("busy_start_hi", HI, 32'd2);

        // reset on the third busy cycle of a divide
        issue(MDU_DIVU, 32'd1000, 32'd3, 1'b1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        exp_q.delete();
        exp_q.push_back({8'd3, {W{1'b0}}, {W{1'b0}}});
        m_hi = '0;
        m_lo = '0;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort_busy", Busy, 0);
        check("abort_hi", HI, 0);
        check("abort_lo", LO, 0);
        issue(MDU_MULTU, 32'd3, 32'd4, 1'b0);
        check("restart_busy", Busy, 1);
        wait_idle();

        // random MDU traffic with occasional starts while busy
        for (int i = 0; i < 40; i++) begin
            op = mdu_ops[$urandom_range(0, 7)];
            ra = $urandom;
            case ($urandom_range(0, 5))
                0:       rb = '0;
                1:       rb = 32'(int'($urandom_range(1, 9)));
                2:       begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                default: rb = $urandom;
            endcase
            issue(op, ra, rb, 1'b1);
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(0, 3)) begin
                    @(posedge clk); #1;
                end
                issue(mdu_ops[$urandom_range(0, 7)], $urandom, $urandom, 1'b0);
            end
        end

        wait_idle();
        repeat (3) @(posedge clk);
        if (exp_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL pending_results: %0d left in queue, expected 0", exp_q.size());
        end
        report();
        $finish;
    end

endmodule
